// File: rtl/xor_stream_descrambler.sv
// xor_stream_descrambler: additive LFSR descrambler (x^7+x^4+1) for a
// valid/ready word stream. The keystream restarts from LfsrSeed on every
// accepted start-of-frame word. Words arriving outside a frame are dropped
// and flagged with a one-cycle drop_pulse.
//
// Optional build macro XOR_DESCR_PARITY_EN: keeps a running XOR of the
// descrambled words of a frame and flags parity_err on the EOF word when that
// word differs from the XOR of the words before it. Without the macro,
// parity_err is tied low.
//
// state | meaning
// IDLE  | outside a frame; only a SOF word is accepted for output
// RUN   | inside a frame; every accepted word is descrambled and emitted

module xor_stream_descrambler #(
   parameter int         NrOfBits = 8,
   parameter logic [6:0] LfsrSeed = 7'h7F
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [NrOfBits-1:0] in_data,
   input  logic                in_valid,
   input  logic                in_sof,
   input  logic                in_eof,
   output logic                in_ready,
   output logic [NrOfBits-1:0] out_data,
   output logic                out_valid,
   output logic                out_sof,
   output logic                out_eof,
   input  logic                out_ready,
   output logic                drop_pulse,
   output logic                parity_err
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Runs NrOfBits LFSR steps; returns {next_state, keystream word (LSB = first step)}.
   function automatic logic [NrOfBits+6:0] lfsr_advance(input logic [6:0] s_in);
      logic [6:0]          s;
      logic [NrOfBits-1:0] ks;
      logic                k;
      s  = s_in;
      ks = '0;
      for (int i = 0; i < NrOfBits; i++) begin
         k     = s[6] ^ s[3];
         ks[i] = k;
         s     = {s[5:0], k};
      end
      return {s, ks};
   endfunction

   state_t              state_q, state_d;
   logic [6:0]          lfsr_q, lfsr_d;
   logic [NrOfBits-1:0] out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                out_sof_q, out_sof_d;
   logic                out_eof_q, out_eof_d;
   logic                drop_pulse_q, drop_pulse_d;

   logic                accept;
   logic                emit;
   logic [6:0]          lfsr_base;
   logic [NrOfBits+6:0] adv;
   logic [NrOfBits-1:0] desc;

   assign in_ready = ~out_valid_q | out_ready;
   assign accept   = in_valid & in_ready;
   // A SOF word always restarts the keystream, even mid-frame.
   assign lfsr_base = in_sof ? LfsrSeed : lfsr_q;
   assign adv       = lfsr_advance(lfsr_base);
   assign desc      = in_data ^ adv[NrOfBits-1:0];
   assign emit      = accept & (in_sof | (state_q == ST_RUN));

   // Next-state for frame tracking, keystream and the output register.
   always_comb begin
      state_d      = state_q;
      lfsr_d       = lfsr_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_sof_d    = out_sof_q;
      out_eof_d    = out_eof_q;
      drop_pulse_d = 1'b0;
      if (out_valid_q & out_ready) begin
         out_valid_d = 1'b0;
      end
      if (emit) begin
         out_valid_d = 1'b1;
         out_data_d  = desc;
         out_sof_d   = in_sof;
         out_eof_d   = in_eof;
         lfsr_d      = adv[NrOfBits+6:NrOfBits];
         state_d     = in_eof ? ST_IDLE : ST_RUN;
      end else if (accept) begin
         drop_pulse_d = 1'b1;
      end
   end

   // Frame FSM, keystream state and registered output stage.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         lfsr_q       <= LfsrSeed;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_sof_q    <= 1'b0;
         out_eof_q    <= 1'b0;
         drop_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_sof_q    <= out_sof_d;
         out_eof_q    <= out_eof_d;
         drop_pulse_q <= drop_pulse_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_sof    = out_sof_q;
   assign out_eof    = out_eof_q;
   assign drop_pulse = drop_pulse_q;

`ifdef XOR_DESCR_PARITY_EN
   logic [NrOfBits-1:0] acc_q, acc_d;
   logic [NrOfBits-1:0] acc_base;
   logic                parity_err_q, parity_err_d;

   assign acc_base = in_sof ? '0 : acc_q;

   // Running XOR of the frame; the EOF word must equal the XOR of its predecessors.
   always_comb begin
      acc_d        = acc_q;
      parity_err_d = parity_err_q;
      if (out_valid_q & out_ready) begin
         parity_err_d = 1'b0;
      end
      if (emit) begin
         if (in_eof) begin
            parity_err_d = (desc != acc_base);
            acc_d        = '0;
         end else begin
            parity_err_d = 1'b0;
            acc_d        = acc_base ^ desc;
         end
      end
   end

   // Parity accumulator and flag registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc_q        <= '0;
         parity_err_q <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Directed bench for xor_stream_descrambler (NrOfBits=8, LfsrSeed=7'h7F).
// A bit-sequence keystream model and a scoreboard queue predict every output;
// a compare process checks the DUT against them each cycle.

module tb_xor_stream_descrambler;

   localparam logic [6:0] SEED = 7'h7F;

   logic       clock;
   logic       reset_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_sof;
   logic       in_eof;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_sof;
   logic       out_eof;
   logic       out_ready;
   logic       drop_pulse;
   logic       parity_err;

   int vectors    = 0;
   int miscompares = 0;

   xor_stream_descrambler #(.NrOfBits(8), .LfsrSeed(SEED)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .in_eof     (in_eof),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_sof    (out_sof),
      .out_eof    (out_eof),
      .out_ready  (out_ready),
      .drop_pulse (drop_pulse),
      .parity_err (parity_err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Keystream as a bit sequence: b[n] = b[n-7] ^ b[n-4], seed bits are the
   // seven bits preceding b[0] (seed bit 6 oldest). Word w is b[8w..8w+7], LSB first.
   function automatic logic [7:0] ks_word(input int w);
      logic       seq [0:527];
      logic [7:0] r;
      for (int j = 0; j < 7; j++) seq[j] = SEED[6-j];
      for (int n = 0; n < 8 * (w + 1); n++) seq[7+n] = seq[n] ^ seq[n+3];
      for (int i = 0; i < 8; i++) r[i] = seq[7 + 8*w + i];
      return r;
   endfunction

   typedef struct packed {
      logic [7:0] d;
      logic       sof;
      logic       eof;
      logic       perr;
   } exp_t;

   exp_t       exp_q[$];
   logic       in_frame = 1'b0;
   int         pos = 0;
   logic [7:0] acc = '0;
   logic       drop_exp = 1'b0;

   // Behavioural model: advances on every clock edge, cleared by reset.
   initial begin
      logic m_valid, m_acc, emit_w;
      exp_t e;
      forever begin
         @(posedge clock or negedge reset_n);
         if (!reset_n) begin
            exp_q.delete();
            in_frame = 1'b0;
            pos      = 0;
            acc      = '0;
            drop_exp = 1'b0;
         end else begin
            m_valid = (exp_q.size() != 0);
            m_acc   = in_valid && (!m_valid || out_ready);
            if (m_valid && out_ready) void'(exp_q.pop_front());
            drop_exp = 1'b0;
            if (m_acc) begin
               if (in_sof) begin
                  pos    = 0;
                  acc    = '0;
                  emit_w = 1'b1;
               end else begin
                  emit_w = in_frame;
               end
               if (emit_w) begin
                  e.d    = in_data ^ ks_word(pos);
                  e.sof  = in_sof;
                  e.eof  = in_eof;
                  e.perr = 1'b0;
`ifdef XOR_DESCR_PARITY_EN
                  if (in_eof) e.perr = (e.d != acc);
                  else        acc    = acc ^ e.d;
`endif
                  pos++;
                  in_frame = !in_eof;
                  exp_q.push_back(e);
               end else begin
                  drop_exp = 1'b1;
               end
            end
         end
      end
   end

   // Compare process: 2 ns after each falling edge, after the driver has settled.
   initial begin
      logic m_valid;
      forever begin
         @(negedge clock);
         #2;
         if (!reset_n) begin
            check("rst_out_valid", out_valid, 1'b0);
         end else begin
            m_valid = (exp_q.size() != 0);
            check("in_ready", in_ready, !m_valid || out_ready);
            check("out_valid", out_valid, m_valid);
            if (m_valid) begin
               check("out_data", out_data, exp_q[0].d);
               check("out_sof", out_sof, exp_q[0].sof);
               check("out_eof", out_eof, exp_q[0].eof);
               check("parity_err", parity_err, exp_q[0].perr);
            end else begin
               check("parity_err_idle", parity_err, 1'b0);
            end
            check("drop_pulse", drop_pulse, drop_exp);
         end
      end
   end

   task automatic drive(input logic [7:0] d, input logic s, input logic e);
      @(negedge clock);
      in_data  = d;
      in_valid = 1'b1;
      in_sof   = s;
      in_eof   = e;
   endtask

   // Waits (bounded) for the currently driven word to be accepted; returns after that edge.
   task automatic wait_accept();
      logic acc_now = 1'b0;
      for (int n = 0; n < 50; n++) begin
         #1;
         acc_now = in_ready;
         @(posedge clock);
         if (acc_now) break;
         @(negedge clock);
      end
      vectors++;
      if (!acc_now) begin
         miscompares++;
         $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 50 cycles");
      end
   endtask

   task automatic send(input logic [7:0] d, input logic s, input logic e);
      drive(d, s, e);
      wait_accept();
   endtask

   // Idle the input at the next falling edge and settle before literal checks.
   task automatic idle_settle();
      @(negedge clock);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eof   = 1'b0;
      #3;
   endtask

   initial begin
      reset_n   = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_eof    = 1'b0;
      out_ready = 1'b1;

      check("model_ks_w0", ks_word(0), 8'h70);
      check("model_ks_w1", ks_word(1), 8'h4F);

      repeat (3) @(negedge clock);
      #1;
      check("rst_drop", drop_pulse, 1'b0);
      check("rst_parity", parity_err, 1'b0);
      check("rst_data", out_data, 8'h00);
      @(negedge clock);
      reset_n = 1'b1;

      // 1: single-word frame, keystream 0x70 cancels data
      send(8'h70, 1'b1, 1'b1);
      idle_settle();
      check("t1_data", out_data, 8'h00);
      check("t1_sof", out_sof, 1'b1);
      check("t1_eof", out_eof, 1'b1);

      // 4: non-SOF word in IDLE (also proves t1 left the FSM in IDLE)
      send(8'h55, 1'b0, 1'b0);
      idle_settle();
      check("t4_drop", drop_pulse, 1'b1);
      check("t4_valid", out_valid, 1'b0);
      @(negedge clock);
      #3;
      check("t4_drop_end", drop_pulse, 1'b0);

      // 2: four back-to-back words of zero
      send(8'h00, 1'b1, 1'b0);
      drive(8'h00, 1'b0, 1'b0);
      #3;
      check("t2_first", out_data, 8'h70);
      check("t2_ready", in_ready, 1'b1);
      wait_accept();
      drive(8'h00, 1'b0, 1'b0);
      #3;
      check("t2_second", out_data, 8'h4F);
      wait_accept();
      send(8'h00, 1'b0, 1'b1);
      idle_settle();

      // 3: consumer stall mid-frame
      send(8'h11, 1'b1, 1'b0);
      send(8'h22, 1'b0, 1'b0);
      drive(8'h33, 1'b0, 1'b0);
      out_ready = 1'b0;
      repeat (5) begin
         @(negedge clock);
         #3;
         check("t3_stall_ready", in_ready, 1'b0);
         check("t3_stall_valid", out_valid, 1'b1);
      end
      @(negedge clock);
      out_ready = 1'b1;
      wait_accept();
      send(8'hA5, 1'b0, 1'b0);
      send(8'h44, 1'b0, 1'b1);
      idle_settle();

      // 5: SOF restart mid-frame, then reset mid-frame
      send(8'h10, 1'b1, 1'b0);
      send(8'h20, 1'b0, 1'b0);
      send(8'h70, 1'b1, 1'b0);
      idle_settle();
      check("t5_restart", out_data, 8'h00);
      send(8'h30, 1'b0, 1'b0);
      @(negedge clock);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      check("t5_rst_valid", out_valid, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      send(8'h99, 1'b0, 1'b0);
      idle_settle();
      check("t5_post_rst_drop", drop_pulse, 1'b1);
      send(8'h70, 1'b1, 1'b1);
      idle_settle();
      check("t5_post_rst_data", out_data, 8'h00);

`ifdef XOR_DESCR_PARITY_EN
      // 6: parity-consistent frame, then corrupted EOF word
      send(8'h12 ^ ks_word(0), 1'b1, 1'b0);
      send(8'h34 ^ ks_word(1), 1'b0, 1'b0);
      send(8'h26 ^ ks_word(2), 1'b0, 1'b1);
      idle_settle();
      check("t6_good_parity", parity_err, 1'b0);
      check("t6_good_eof", out_eof, 1'b1);
      send(8'h12 ^ ks_word(0), 1'b1, 1'b0);
      send(8'h34 ^ ks_word(1), 1'b0, 1'b0);
      send(8'h27 ^ ks_word(2), 1'b0, 1'b1);
      idle_settle();
      check("t6_bad_parity", parity_err, 1'b1);
      check("t6_bad_eof", out_eof, 1'b1);
      send(8'h5A ^ ks_word(0), 1'b1, 1'b1);
      idle_settle();
      check("t6_single_parity", parity_err, 1'b1);
`endif

      repeat (3) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
